// File: rtl/subneg_loader.sv
// ---------------------------------------------------------------------------
// subneg_loader
//   Host-side program loader for the SUBNEG core. It parses a framed byte
//   stream and writes instruction words into mem_rom or operands into
//   mem_data. The core is held in reset while a load is in progress and is
//   released by a RUN command.
//
//   Frame format : CMD, ADDR, LEN, LEN data bytes, CHK  (LEN = 0 -> 256)
//   Commands     : 0x01 LOAD_ROM, 0x02 LOAD_DATA, 0x03 RUN, 0x04 HALT,
//                  0x05 CLRERR; any other byte in IDLE sets err.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_data    in   WIDTH  stream byte
//   in_valid   in   1      in_data valid
//   in_ready   out  1      byte accepted when in_valid && in_ready
//   mem_wr_en  out  1      one-cycle write strobe
//   mem_sel    out  1      0 = mem_rom, 1 = mem_data
//   mem_addr   out  WIDTH  write address
//   mem_wdata  out  WIDTH  write data
//   cpu_rst    out  1      core reset (1 = held)
//   busy       out  1      load frame in progress
//   err        out  1      sticky checksum / unknown-command flag
// ---------------------------------------------------------------------------
module subneg_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_wr_en,
    output logic             mem_sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_rst,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    localparam logic [WIDTH-1:0] CMD_LOAD_ROM  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CMD_LOAD_DATA = WIDTH'(2);
    localparam logic [WIDTH-1:0] CMD_RUN       = WIDTH'(3);
    localparam logic [WIDTH-1:0] CMD_HALT      = WIDTH'(4);
    localparam logic [WIDTH-1:0] CMD_CLRERR    = WIDTH'(5);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    // One extra bit so that a LEN byte of zero can stand for 2^WIDTH words.
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             in_ready_q;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic             mem_sel_q, mem_sel_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] chk_sum;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    // NOTE: every variable gets a default before the case statement so that
    // no path leaves one unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_wr_en_d = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        err_d       = err_q;
        chk_sum     = sum_q + in_data;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    case (in_data)
                        CMD_LOAD_ROM, CMD_LOAD_DATA: begin
                            mem_sel_d = in_data[1];
                            cpu_rst_d = 1'b1;
                            state_d   = S_ADDR;
                        end
                        CMD_RUN:    cpu_rst_d = 1'b0;
                        CMD_HALT:   cpu_rst_d = 1'b1;
                        CMD_CLRERR: err_d     = 1'b0;
                        default:    err_d     = 1'b1;
                    endcase
                end
                S_ADDR: begin
                    addr_d  = in_data;
                    sum_d   = in_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d   = (in_data == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, in_data};
                    sum_d   = sum_q + in_data;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + WIDTH'(1);  // wraps modulo 2^WIDTH
                    sum_d       = sum_q + in_data;
                    cnt_d       = cnt_q - (WIDTH+1)'(1);
                    if (cnt_q == (WIDTH+1)'(1)) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (chk_sum != '0) begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            in_ready_q  <= 1'b1;
            mem_wr_en_q <= mem_wr_en_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_subneg_loader.sv
// ---------------------------------------------------------------------------
// tb_subneg_loader
//   Scoreboard bench for subneg_loader. Frames are built as byte lists; the
//   expected memory writes (select, address, data, cycle) are derived from
//   the frame contents and queued as each data byte is issued. A monitor
//   pops and compares whenever mem_wr_en is seen. Command-level flags
//   (err, cpu_rst, busy) are tracked by a small model and checked after
//   each command or frame.
// ---------------------------------------------------------------------------
module tb_subneg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mem_wr_en;
    logic       mem_sel;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       busy;
    logic       err;

    subneg_loader #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wr_en (mem_wr_en),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] fd[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       exp_err = 1'b0;
    logic       exp_cpu_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", {mem_sel, mem_addr, mem_wdata}, 32'h0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_sel",   32'(mem_sel),   32'(e.sel));
                check("wr_addr",  32'(mem_addr),  32'(e.addr));
                check("wr_data",  32'(mem_wdata), 32'(e.data));
                check("wr_cycle", 32'(cyc),       32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit exp_wr,
                             input logic sel, input logic [7:0] addr);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 32'(in_ready), 32'h1);
        if (exp_wr) sb.push_back('{sel: sel, addr: addr, data: b, cyc: cyc + 1});
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic exp_busy);
        check({tag, "_err"},     32'(err),     32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_cpu_rst));
        check({tag, "_busy"},    32'(busy),    32'(exp_busy));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_wr_en",     32'(mem_wr_en), 32'h0);
        check("rst_mem_sel",   32'(mem_sel),   32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_err",       32'(err),       32'h0);
        check("rst_cpu_rst",   32'(cpu_rst),   32'h1);
        in_valid = 1'b0;
        rst      = 1'b0;
        exp_err     = 1'b0;
        exp_cpu_rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
    endtask

    // Single-byte command in IDLE, with the model's view of its effect.
    task automatic send_cmd(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0, 8'h00);
        case (b)
            8'h03:   exp_cpu_rst = 1'b0;
            8'h04:   exp_cpu_rst = 1'b1;
            8'h05:   exp_err     = 1'b0;
            default: exp_err     = 1'b1;
        endcase
        check_flags("cmd", 1'b0);
    endtask

    // Load frame from the bytes in fd (1..256 of them). chk_override < 0
    // sends the correct two's-complement checksum.
    task automatic load_frame(input logic sel, input logic [7:0] addr,
                              input int chk_override, input int max_gap);
        int         len;
        logic [7:0] len_b;
        logic [7:0] sum;
        logic [7:0] chk;
        len   = fd.size();
        len_b = 8'(len);
        send_byte(sel ? 8'h02 : 8'h01, 1'b0, 1'b0, 8'h00);
        exp_cpu_rst = 1'b1;
        check_flags("frame_start", 1'b1);
        check("frame_mem_sel", 32'(mem_sel), 32'(sel));
        send_byte(addr, 1'b0, 1'b0, 8'h00);
        send_byte(len_b, 1'b0, 1'b0, 8'h00);
        sum = addr + len_b;
        for (int i = 0; i < len; i++) begin
            send_byte(fd[i], 1'b1, sel, addr + 8'(i));
            sum = sum + fd[i];
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        chk = 8'h00 - sum;
        if (chk_override >= 0) chk = 8'(chk_override);
        if (8'(sum + chk) != 8'h00) exp_err = 1'b1;
        send_byte(chk, 1'b0, 1'b0, 8'h00);
        check_flags("frame_end", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Directed ROM load; checksum computed from the frame bytes.
        fd = '{8'hAA, 8'hBB, 8'hCC};
        load_frame(1'b0, 8'h10, -1, 0);

        // Data-memory load wrapping the address 0xFF -> 0x00.
        fd = '{8'h11, 8'h22, 8'h33};
        load_frame(1'b1, 8'hFE, -1, 0);

        // Bad checksum: writes still happen, err sets, CLRERR clears it.
        fd = '{8'hAA, 8'hBB, 8'hCC};
        load_frame(1'b0, 8'h10, 0, 0);
        check("bad_chk_err", 32'(err), 32'h1);
        send_cmd(8'h05);

        // cpu_rst control: RUN releases, load re-holds, HALT holds.
        do_reset();
        send_cmd(8'h03);
        check("run_cpu_rst", 32'(cpu_rst), 32'h0);
        fd = '{8'h5A};
        load_frame(1'b0, 8'h40, -1, 0);
        send_cmd(8'h04);

        // LEN = 0 means 256 words, with random in_valid gaps.
        fd.delete();
        for (int i = 0; i < 256; i++) fd.push_back(8'($urandom));
        load_frame(1'b1, 8'h00, -1, 2);

        // Randomized mix of frames and commands.
        for (int n = 0; n < 20; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                fd.delete();
                for (int i = 0; i < $urandom_range(1, 12); i++) fd.push_back(8'($urandom));
                load_frame(1'($urandom), 8'($urandom),
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1, 1);
            end else if (r == 6) begin
                send_cmd(8'h03);
            end else if (r == 7) begin
                send_cmd(8'h04);
            end else if (r == 8) begin
                send_cmd(8'h05);
            end else begin
                send_cmd(8'($urandom_range(6, 255)));
            end
        end

        // Reset after the 2nd data byte of a 5-byte load aborts the frame.
        send_byte(8'h01, 1'b0, 1'b0, 8'h00);
        send_byte(8'h20, 1'b0, 1'b0, 8'h00);
        send_byte(8'h05, 1'b0, 1'b0, 8'h00);
        send_byte(8'hD0, 1'b1, 1'b0, 8'h20);
        send_byte(8'hD1, 1'b1, 1'b0, 8'h21);
        in_data  = 8'hD2;
        in_valid = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);

        fd = '{8'h01, 8'h02};
        load_frame(1'b1, 8'h80, -1, 0);
        send_cmd(8'h7E);
        check("unknown_cmd_err", 32'(err), 32'h1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
